// File: rtl/spi_switch_sequencer.sv
// Hardware sequencer: debounces the switch bank and ships each settled value as one
// 16-bit mode-0 SPI frame, capturing the slave's reply word in the same frame.
module spi_switch_sequencer #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SETTLE_CYCLES = 1000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [9:0]  sw_in,
    input  logic        start,
    input  logic        spi_MISO,
    output logic        spi_MOSI,
    output logic        spi_SCLK,
    output logic        spi_SS_n,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic [7:0]  frame_count
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t state, state_next;

    logic [9:0]    sw_meta, sw_sync, sw_prev, last_sent;
    logic [CW-1:0] stable_cnt;
    logic [DW-1:0] div_cnt;
    logic          div_done;
    logic [3:0]    bit_cnt;
    logic          phase_high;
    logic [15:0]   tx_sr, rx_sr;
    logic          pending, trigger, request, launch;

    assign div_done = (div_cnt == DIV_LAST);
    assign trigger  = (stable_cnt == SETTLE_MAX) && (sw_sync != last_sent);
    assign request  = trigger | start;
    assign launch   = (state == IDLE) && (request | pending);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            sw_prev    <= '0;
            stable_cnt <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev)
                stable_cnt <= '0;
            else if (stable_cnt != SETTLE_MAX)
                stable_cnt <= stable_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (launch) state_next = SETUP;
            SETUP: if (div_done) state_next = SHIFT;
            SHIFT: if (div_done && !phase_high && bit_cnt == 4'd15) state_next = HOLD;
            HOLD:  if (div_done) state_next = GAP;
            GAP:   if (div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            phase_high  <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            last_sent   <= '0;
            pending     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_count <= '0;
        end else begin
            rx_valid <= 1'b0;
            div_cnt  <= (state == IDLE || div_done) ? '0 : div_cnt + DW'(1);

            if (launch) begin
                tx_sr     <= {4'b1010, 2'b00, sw_sync};
                last_sent <= sw_sync;
                pending   <= 1'b0;
            end else if (state != IDLE && request) begin
                pending <= 1'b1;
            end

            if (state == SETUP && div_done) begin
                phase_high <= 1'b1;
                bit_cnt    <= '0;
            end

            if (state == SHIFT) begin
                if (phase_high && div_cnt == '0)
                    rx_sr <= {rx_sr[14:0], spi_MISO};
                if (div_done) begin
                    phase_high <= !phase_high;
                    if (!phase_high)
                        bit_cnt <= bit_cnt + 4'd1;
                    // MOSI moves with the falling SCLK edge; the final bit is held into HOLD
                    else if (bit_cnt != 4'd15)
                        tx_sr <= {tx_sr[14:0], 1'b0};
                end
            end

            if (state == HOLD && div_done) begin
                rx_data     <= rx_sr;
                rx_valid    <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    always_comb begin
        spi_SS_n = 1'b1;
        spi_SCLK = 1'b0;
        spi_MOSI = 1'b0;
        busy     = (state != IDLE);
        if (state == SETUP || state == SHIFT || state == HOLD) begin
            spi_SS_n = 1'b0;
            spi_MOSI = tx_sr[15];
            spi_SCLK = (state == SHIFT) && phase_high;
        end
    end

endmodule

// File: doc/spi_switch_sequencer.md
# spi_switch_sequencer

Sequences the SPI master port of the switch-to-SPI subsystem in hardware. It watches the 10-bit switch bank, waits until a changed value has been stable long enough, then shifts one 16-bit mode-0 frame out on MOSI while capturing 16 bits from MISO. The block sits between the board switches and the external SPI pins, alongside the soft-processor path, and owns SS_n/SCLK/MOSI while enabled.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 1..255.
- SETTLE_CYCLES, 1000: consecutive stable cycles required before a switch change triggers a frame; legal range 2..2^20.
- clk_clk  in  1  system clock; every register is clocked on its rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- sw_in  in  10  raw switch bank; passes through an internal two-flop synchronizer.
- start  in  1  one-cycle request that forces a frame with the current synced switch value.
- spi_MISO  in  1  serial data from the slave.
- spi_MOSI  out  1  serial data to the slave, MSB first.
- spi_SCLK  out  1  serial clock, idles low.
- spi_SS_n  out  1  active-low slave select.
- rx_data  out  16  last fully received MISO word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high from trigger acceptance until return to IDLE.
- frame_count  out  8  completed frames; wraps 255 -> 0.

## Operation
- TX word: {4'b1010, 2'b00, sw_sync[9:0]}. It is latched into the shift register on the IDLE -> SETUP transition.
- Change detector:
  - A stable counter clears whenever sw_sync differs from its previous-cycle value. Otherwise it increments, saturating at SETTLE_CYCLES.
  - A trigger fires when the counter equals SETTLE_CYCLES and sw_sync != last_sent.
  - last_sent updates to the transmitted value at SETUP entry.
- Any trigger or start arriving while busy sets a single pending flag. Multiple requests merge into one pending frame.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE -> SETUP on trigger, start, or pending; this transition clears pending.
  - SETUP lasts CLK_DIV cycles. SS_n is low, SCLK is low, MOSI = bit 15.
  - SHIFT runs 16 bit periods. Each period is SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - MISO is sampled into the RX shift register on the cycle SCLK rises.
    - MOSI advances to the next bit on the cycle SCLK falls, except after bit 0.
  - HOLD lasts CLK_DIV cycles with SCLK low and SS_n low.
  - GAP lasts CLK_DIV cycles. SS_n is high and MOSI = 0. On GAP entry, rx_data loads, rx_valid pulses and frame_count increments.
  - GAP -> IDLE, then IDLE immediately re-enters SETUP if a trigger is pending.
- A simultaneous start and switch trigger in IDLE produce exactly one frame.
- Switch changes during a frame do not alter the frame in flight. They are evaluated against the updated last_sent afterwards.

## Timing
- Reset values: spi_SS_n=1, spi_SCLK=0, spi_MOSI=0, rx_data=0, rx_valid=0, busy=0, frame_count=0, last_sent=0, pending=0, state IDLE.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously). The partial frame is discarded with no rx_valid.
- Latency sw_in -> sw_sync is 2 cycles. With sw_in steady, a trigger fires SETTLE_CYCLES cycles later.
- Trigger or start seen in cycle N gives busy=1 and SS_n=0 in cycle N+1.
- SS_n stays low for 34*CLK_DIV cycles (136 at CLK_DIV=4).
- The first SCLK rise comes CLK_DIV cycles after SS_n falls.
- rx_valid pulses in the same cycle SS_n rises.
- Frame-to-frame minimum: 35*CLK_DIV cycles from one SS_n fall to the next, plus 1 IDLE cycle.

## Test plan
- Reset release with sw_in=0 for 5000 cycles -> no frame; SS_n=1, frame_count=0.
- sw_in=10'h3A5, SETTLE_CYCLES=1000, CLK_DIV=4 -> one frame; MOSI bits = 16'hA3A5 MSB first; SS_n low for 136 cycles; frame_count=1.
- Slave model drives MISO=16'hC3E1 -> rx_data=16'hC3E1 with a one-cycle rx_valid at the SS_n rising edge.
- sw_in toggles every 500 cycles with SETTLE_CYCLES=1000 -> no frame. Switches then hold 10'h001 -> exactly one frame with 16'hA001.
- Three start pulses during one frame -> exactly one extra frame; its SS_n falls CLK_DIV+1 cycles after the previous SS_n rise.
- reset_reset pulsed at the 8th SCLK rise -> SS_n=1 and SCLK=0 the same cycle; no rx_valid; frame_count unchanged at 0.
